// File: rtl/uart_rx_receiver.sv
// ---------------------------------------------------------------------------
// uart_rx_receiver
//   8N1 UART receiver (idle high, LSB first) with a valid/ready output stage.
//   The serial line is synchronized through two flops. The start bit is
//   confirmed at its mid-point, and each data bit and the stop bit is sampled
//   one bit period after the previous sample.
//
// Ports
//   i_clk        system clock; all state changes on its rising edge
//   i_rst_n      synchronous active-low reset
//   i_uart_rx    asynchronous serial input
//   o_data       last correctly framed byte
//   o_valid      o_data holds an unconsumed byte
//   i_ready      consumer accepts o_data in this cycle
//   o_frame_err  one-cycle pulse: stop bit sampled low (byte discarded)
//   o_overrun    one-cycle pulse: good byte arrived while o_valid=1 and
//                i_ready=0 (new byte dropped, o_data held)
//   o_dbg_state  current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP,
//                4 WAIT_HIGH)
//
// Handshake: a byte transfers in every cycle where o_valid && i_ready.
// o_valid then drops on the next edge unless a new byte loads in that same
// cycle. While o_valid=1 and not accepted, o_data does not change.
// ---------------------------------------------------------------------------
module uart_rx_receiver #(
    parameter int clk_freq_hz = 0,
    parameter int baud_rate   = 1000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_uart_rx,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic [2:0] o_dbg_state
);

    localparam int BIT_T  = clk_freq_hz / baud_rate;
    localparam int HALF_T = BIT_T / 2;
    localparam int CNT_W  = $clog2(BIT_T) + 1;

    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_T - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_T - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       bit_idx_q,   bit_idx_d;
    logic [7:0]       shift_q,     shift_d;
    logic [7:0]       data_q,      data_d;
    logic             valid_q,     valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q,   overrun_d;
    logic             sync1_q,     sync1_d;
    logic             rx_s_q,      rx_s_d;

    always_comb begin
        sync1_d     = i_uart_rx;
        rx_s_d      = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        // An accepted byte clears o_valid unless a new byte reloads it below.
        valid_d     = valid_q & ~i_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    if (!rx_s_q) begin
                        state_d   = ST_DATA;
                        cnt_d     = BIT_LOAD;
                        bit_idx_d = 3'd0;
                    end else begin
                        // Line went back high before mid-bit: a glitch.
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    // Shift in at the MSB so the first bit ends up at bit 0.
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    cnt_d     = BIT_LOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (rx_s_q) begin
                        // Going straight to IDLE lets a start bit that
                        // immediately follows the stop bit be detected.
                        state_d = ST_IDLE;
                        if (!valid_q || i_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_WAIT_HIGH: begin
                // Break or stuck-low line: ignore it until the line is idle again.
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_receiver
//   Bench for uart_rx_receiver at 10 MHz / 1 Mbaud (10 clocks per bit).
//   Frames are modelled at byte level: a frame with a good stop bit either
//   delivers its byte or, if an earlier byte is still held while i_ready=0,
//   counts as an overrun; a bad stop bit counts as a framing error.
//   Inputs change 1 time unit after the rising edge; outputs are observed on
//   the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_receiver;
    localparam int CLK_HZ  = 10_000_000;
    localparam int BAUD    = 1_000_000;
    localparam int BIT_T   = 10;
    localparam int LAT_MAX = 2 + 5 + 9 * BIT_T + 1;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd4;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_uart_rx = 1'b1;
    logic       i_ready = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic [2:0] o_dbg_state;

    uart_rx_receiver #(.clk_freq_hz(CLK_HZ), .baud_rate(BAUD)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_uart_rx   (i_uart_rx),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before the end of stimulus");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   fe_cnt = 0, ov_cnt = 0, acc_cnt = 0;
    int   exp_fe = 0, exp_ov = 0;
    bit   model_held = 0;
    int   fall_cyc = 0, rise_cyc = 0;
    logic       prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string name, input int act, input int exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_valid && !prev_valid) rise_cyc = cyc;
            if (o_valid && i_ready) begin
                acc_cnt++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL accept_unexpected: got byte %02h, expected none", o_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (o_data !== e) begin
                        miscompares++;
                        $display("FAIL accept_data: got %02h, expected %02h", o_data, e);
                    end
                end
            end
            if (prev_valid && !prev_ready) begin
                vectors++;
                if (!o_valid || o_data !== prev_data) begin
                    miscompares++;
                    $display("FAIL hold_stable: got valid=%0b data=%02h, expected valid=1 data=%02h",
                             o_valid, o_data, prev_data);
                end
            end
            if (o_frame_err) fe_cnt++;
            if (o_overrun) ov_cnt++;
            if (o_frame_err || o_overrun) begin
                vectors++;
                if ((o_frame_err && o_overrun) || (o_valid && !prev_valid)) begin
                    miscompares++;
                    $display("FAIL pulse_exclusive: got fe=%0b ov=%0b new_valid=%0b, expected one alone",
                             o_frame_err, o_overrun, o_valid && !prev_valid);
                end
            end
            prev_valid = o_valid;
            prev_ready = i_ready;
            prev_data  = o_data;
        end else begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_data  = 8'h00;
        end
    end

    // ---------------- reference model + drivers ----------------
    task automatic model_frame(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            exp_fe++;
        end else if (model_held && !i_ready) begin
            exp_ov++;
        end else begin
            exp_q.push_back(b);
            model_held = !i_ready;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        i_uart_rx = b;
        tick(BIT_T);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        model_frame(b, stop_ok);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok ? 1'b1 : 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base_acc, base_fe, base_ov, lat, gap;
        logic [7:0] rb;
        bit ok;

        tick(5);
        check("reset_valid", o_valid, 0);
        check("reset_data", o_data, 0);
        check("reset_frame_err", o_frame_err, 0);
        check("reset_overrun", o_overrun, 0);
        check("reset_state", o_dbg_state, S_IDLE);
        i_rst_n = 1'b1;
        tick(5);

        // Single byte with consumer ready
        base_acc = acc_cnt;
        send_frame(8'hA5, 1'b1);
        tick(20);
        lat = rise_cyc - fall_cyc;
        check("a5_accepts", acc_cnt - base_acc, 1);
        check("a5_latency_within_bound", (lat > 0 && lat <= LAT_MAX) ? 1 : 0, 1);
        check("a5_frame_err", fe_cnt, exp_fe);
        check("a5_overrun", ov_cnt, exp_ov);

        // Short low glitch on an idle line
        base_acc = acc_cnt;
        base_fe = fe_cnt;
        i_uart_rx = 1'b0;
        tick(3);
        i_uart_rx = 1'b1;
        tick(20);
        check("glitch_accepts", acc_cnt - base_acc, 0);
        check("glitch_frame_err", fe_cnt - base_fe, 0);
        check("glitch_state", o_dbg_state, S_IDLE);

        // Bad stop bit, then line held low
        base_acc = acc_cnt;
        send_frame(8'h3C, 1'b0);
        tick(30);
        check("ferr_wait_state", o_dbg_state, S_WAIT);
        check("ferr_count", fe_cnt, exp_fe);
        check("ferr_accepts", acc_cnt - base_acc, 0);
        i_uart_rx = 1'b1;
        tick(10);
        check("ferr_back_idle", o_dbg_state, S_IDLE);

        // Consumer stalled across two back-to-back frames
        i_ready = 1'b0;
        base_acc = acc_cnt;
        base_ov = ov_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(5);
        check("ovr_held_valid", o_valid, 1);
        check("ovr_held_data", o_data, 8'h11);
        check("ovr_pulses", ov_cnt - base_ov, 1);
        check("ovr_count_model", ov_cnt, exp_ov);
        i_ready = 1'b1;
        model_held = 0;
        tick(5);
        check("ovr_release_accepts", acc_cnt - base_acc, 1);

        // Reset during bit 4 of 8'hFF, then a clean frame
        base_acc = acc_cnt;
        base_fe = fe_cnt;
        base_ov = ov_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        tick(4);
        i_rst_n = 1'b0;
        tick(3);
        i_rst_n = 1'b1;
        model_held = 0;
        tick(60);
        check("rst_abort_accepts", acc_cnt - base_acc, 0);
        check("rst_abort_pulses", (fe_cnt - base_fe) + (ov_cnt - base_ov), 0);
        check("rst_abort_state", o_dbg_state, S_IDLE);
        send_frame(8'h5A, 1'b1);
        tick(20);
        check("rst_then_5a_accepts", acc_cnt - base_acc, 1);

        // Back-to-back 00 then FF with no idle gap
        base_acc = acc_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(20);
        check("b2b_accepts", acc_cnt - base_acc, 2);

        // Random frames: random data, occasional bad stop bit, random gaps
        for (int n = 0; n < 40; n++) begin
            rb = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 7) != 0);
            send_frame(rb, ok);
            gap = $urandom_range(0, 5);
            if (!ok) gap = gap + 3;
            i_uart_rx = 1'b1;
            tick(gap);
        end
        tick(30);

        check("final_queue_empty", exp_q.size(), 0);
        check("final_frame_err", fe_cnt, exp_fe);
        check("final_overrun", ov_cnt, exp_ov);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx_receiver.md
UART_RX_RECEIVER -- requirements
Module: uart_rx_receiver

Interface
REQ-001 Parameter clk_freq_hz, default 0, SHALL give the system clock frequency in Hz; valid instances set it so that clk_freq_hz/baud_rate >= 4.
REQ-002 Parameter baud_rate, default 1000000, SHALL give the serial bit rate in bit/s.
REQ-003 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 i_uart_rx  input  1  SHALL be the asynchronous serial line; idle high, 8N1 framing, LSB first.
REQ-006 o_data  output  8  SHALL carry the last correctly framed byte.
REQ-007 o_valid  output  1  SHALL mean that o_data holds an unconsumed byte.
REQ-008 i_ready  input  1  SHALL mean that the consumer accepts o_data in this cycle.
REQ-009 o_frame_err  output  1  SHALL be a one-cycle pulse when a stop bit samples low.
REQ-010 o_overrun  output  1  SHALL be a one-cycle pulse when a good byte completes while o_valid=1.

Function
REQ-011 Constants: BIT_T = clk_freq_hz/baud_rate (integer division); HALF_T = BIT_T/2; counter width = $clog2(BIT_T)+1.
REQ-012 i_uart_rx SHALL pass through a 2-flop synchronizer (both flops = 1 at reset); all logic uses the synchronized value rx_s.
REQ-013 States: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: rx_s=0 -> START, with the counter loaded to HALF_T-1.
REQ-015 START: the counter decrements each cycle; at 0, sample rx_s; 0 -> DATA (counter = BIT_T-1, bit index = 0); 1 -> IDLE (glitch rejected, no output).
REQ-016 DATA: at counter 0, shift rx_s into the shift register MSB-first-in so that the first received bit ends at bit 0, and reload the counter to BIT_T-1; after the 8th sample -> STOP.
REQ-017 STOP: at counter 0, sample rx_s. 1 -> good byte handling (REQ-018), then IDLE. 0 -> o_frame_err=1 for one cycle, byte discarded, o_data/o_valid unchanged, -> WAIT_HIGH.
REQ-018 Good byte with o_valid=0, or o_valid=1 && i_ready=1 in the same cycle: o_data <= shift register, o_valid <= 1 next cycle. Good byte with o_valid=1 && i_ready=0: o_overrun=1 for one cycle, new byte dropped, o_data held.
REQ-019 WAIT_HIGH: remain until rx_s=1 (break/line-low handling), then IDLE; no start detection while in WAIT_HIGH.
REQ-020 Handshake: o_valid && i_ready in a cycle -> o_valid=0 next cycle unless REQ-018 reloads it in that same cycle; o_data SHALL be stable while o_valid=1 and not accepted.
REQ-021 Latency: o_valid rises at most 2 (synchronizer) + HALF_T + 9*BIT_T + 1 cycles after the start-bit falling edge on i_uart_rx.
REQ-022 o_frame_err and o_overrun SHALL never be asserted in the same cycle, and neither SHALL be asserted together with a new o_valid load.
REQ-023 The receiver SHALL accept back-to-back frames: a start bit immediately following a 1 stop bit SHALL be detected.

Reset
REQ-024 i_rst_n=0 at a clock edge -> state IDLE, counter 0, bit index 0, shift register 0, synchronizer flops 1, o_data=8'h00, o_valid=0, o_frame_err=0, o_overrun=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, the receiver waits in IDLE for the next falling edge.

Verification (clk_freq_hz=10_000_000, baud_rate=1_000_000 -> BIT_T=10, HALF_T=5)
REQ-026 Send 8'hA5 with 10-cycle bits, i_ready=1 -> one o_valid cycle with o_data=8'hA5, no error pulses, within the REQ-021 bound.
REQ-027 3-cycle low glitch on an idle line -> no o_valid, no o_frame_err, state back in IDLE.
REQ-028 Send 8'h3C with stop bit 0, then hold the line low for 30 cycles -> one o_frame_err pulse, no o_valid, no new start until the line returns high.
REQ-029 i_ready=0, send 8'h11 then 8'h22 back-to-back -> o_data=8'h11 held with o_valid=1, one o_overrun pulse at the end of 8'h22; raising i_ready then yields one accept of 8'h11.
REQ-030 Assert i_rst_n=0 during bit 4 of 8'hFF, release, then send 8'h5A -> no output for the aborted frame, then o_data=8'h5A with o_valid=1.
REQ-031 Send 8'h00 and then 8'hFF with no idle gap between frames -> two good bytes delivered in order.
